// File: rtl/noc_flat_port_bridge.sv
// noc_flat_port_bridge: per-endpoint credit-counted injection stage and credit-returning
// ejection FIFO between tile cores and flattened NoC local-port vectors.
// Optional macro PRONOC_BRIDGE_CREDIT_CHECK_EN builds the sticky err_all protocol detector.
module noc_flat_port_bridge #(
   parameter int NE     = 16,
   parameter int V      = 2,
   parameter int Fw     = 36,
   parameter int B      = 4,
   parameter int VC_LSB = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NE*Fw-1:0] inj_flit_all,
   input  logic [NE*V-1:0]  inj_vc_all,
   input  logic [NE-1:0]    inj_valid_all,
   output logic [NE-1:0]    inj_ready_all,
   output logic [NE*Fw-1:0] flit_out_all,
   output logic [NE-1:0]    flit_out_wr_all,
   input  logic [NE*V-1:0]  credit_in_all,
   input  logic [NE*Fw-1:0] flit_in_all,
   input  logic [NE-1:0]    flit_in_wr_all,
   output logic [NE*V-1:0]  credit_out_all,
   output logic [NE*Fw-1:0] ej_flit_all,
   output logic [NE-1:0]    ej_valid_all,
   input  logic [NE-1:0]    ej_ready_all,
   output logic [NE-1:0]    err_all
);
   localparam int CW    = $clog2(B + 1);
   localparam int DEPTH = V * B;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW    = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(B);
   localparam logic [NW-1:0] FIFO_MAX = NW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   // Handshake: inj and ej transfer on a rising edge where valid && ready are both high;
   // valid never depends on ready. flit_in_wr and credit_in are strobes without back-pressure.
   for (genvar i = 0; i < NE; i++) begin : g_ep
      logic [Fw-1:0] inj_flit, flit_in, head, flit_out_q;
      logic [V-1:0]  inj_vc, credit_in, cred_nz, cred_full, credit_out_q;
      logic          inj_valid, flit_in_wr, ej_ready, vc_onehot, send, flit_out_wr_q;
      logic [CW-1:0] cred [V];

      assign inj_flit   = inj_flit_all[i*Fw +: Fw];
      assign inj_vc     = inj_vc_all[i*V +: V];
      assign inj_valid  = inj_valid_all[i];
      assign credit_in  = credit_in_all[i*V +: V];
      assign flit_in    = flit_in_all[i*Fw +: Fw];
      assign flit_in_wr = flit_in_wr_all[i];
      assign ej_ready   = ej_ready_all[i];

      always_comb begin
         cred_nz   = '0;
         cred_full = '0;
         for (int v = 0; v < V; v++) begin
            cred_nz[v]   = (cred[v] != '0);
            cred_full[v] = (cred[v] == CRED_MAX);
         end
      end

      assign vc_onehot = (inj_vc != '0) && ((inj_vc & (inj_vc - V'(1))) == '0);
      assign inj_ready_all[i] = vc_onehot && (|(inj_vc & cred_nz));
      assign send = inj_valid && inj_ready_all[i];

      // A send and a returning credit on the same VC cancel; credits saturate at B.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            for (int v = 0; v < V; v++) cred[v] <= CRED_MAX;
         end else begin
            for (int v = 0; v < V; v++) begin
               if (send && inj_vc[v] && !credit_in[v])
                  cred[v] <= cred[v] - CW'(1);
               else if (credit_in[v] && !(send && inj_vc[v]) && !cred_full[v])
                  cred[v] <= cred[v] + CW'(1);
            end
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            flit_out_q    <= '0;
            flit_out_wr_q <= 1'b0;
         end else begin
            flit_out_wr_q <= send;
            if (send) flit_out_q <= inj_flit;
         end
      end

      assign flit_out_all[i*Fw +: Fw] = flit_out_q;
      assign flit_out_wr_all[i]       = flit_out_wr_q;

      logic [Fw-1:0] mem [DEPTH];
      logic [PW-1:0] rd_ptr, wr_ptr;
      logic [NW-1:0] count;
      logic          fifo_nempty, fifo_full, pop, push;

      assign fifo_nempty = (count != '0);
      assign fifo_full   = (count == FIFO_MAX);
      assign pop         = fifo_nempty && ej_ready;
      // A pop frees the slot in the same cycle, so a full FIFO still accepts push+pop.
      assign push        = flit_in_wr && (!fifo_full || pop);
      assign head        = mem[rd_ptr];

      always_ff @(posedge clk) begin
         if (push) mem[wr_ptr] <= flit_in;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            credit_out_q <= '0;
         end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
               2'b10:   count <= count + NW'(1);
               2'b01:   count <= count - NW'(1);
               default: count <= count;
            endcase
            credit_out_q <= pop ? head[VC_LSB +: V] : '0;
         end
      end

      assign ej_valid_all[i]         = fifo_nempty;
      assign ej_flit_all[i*Fw +: Fw] = fifo_nempty ? head : '0;
      assign credit_out_all[i*V +: V] = credit_out_q;

`ifdef PRONOC_BRIDGE_CREDIT_CHECK_EN
      logic err_q;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            err_q <= 1'b0;
         else if ((|(credit_in & cred_full)) || (flit_in_wr && fifo_full && !pop) ||
                  (inj_valid && !vc_onehot))
            err_q <= 1'b1;
      end
      assign err_all[i] = err_q;
`else
      assign err_all[i] = 1'b0;
`endif
   end
endmodule
